reg_wb_arbiter: RTL and testbench
=================================

Name: reg_wb_arbiter

Overview:
Shares the register file's single write port between two writeback sources: the ALU result path and the load-return (memory) path. Each source has a one-entry holding slot behind a valid/ready handshake. The block arbitrates between them with fixed priority plus an anti-starvation counter, and drives registered wr_en/wr_addr/wr_data into the register file. It also reports pending-write hazards on two read addresses so decode can stall.

Parameters:
DATA_W, 32, write data width
ADDR_W, 5, register address width
STARVE_LIMIT, 3, consecutive lost cycles after which the ALU source gets priority (legal range 1..15)
DROP_R0, 1, when 1 a write to address 0 is accepted and discarded

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
alu_valid  input  1  ALU writeback request
alu_ready  output  1  ALU request accepted when valid&ready
alu_addr  input  ADDR_W  ALU destination register
alu_data  input  DATA_W  ALU result
mem_valid  input  1  load writeback request
mem_ready  output  1  load request accepted when valid&ready
mem_addr  input  ADDR_W  load destination register
mem_data  input  DATA_W  load data
wr_en  output  1  register file write enable
wr_addr  output  ADDR_W  register file write address
wr_data  output  DATA_W  register file write data
chk0_addr  input  ADDR_W  read address 0 to hazard-check
chk1_addr  input  ADDR_W  read address 1 to hazard-check
chk0_hit  output  1  pending write targets chk0_addr
chk1_hit  output  1  pending write targets chk1_addr

Behaviour:
- Reset (rst high at an edge): both slots empty, wr_en=0, wr_addr=0, wr_data=0, starve count=0. Slots already in flight are discarded. While rst is high, alu_ready=0 and mem_ready=0. From the first cycle after reset, both readies are 1.
- Slot per source: full flag, addr, data. ready = !full || granted_this_cycle. ready depends only on registered state, so there is no combinational valid->ready path.
- Accept (valid&ready at edge): the slot loads addr/data and sets full. If DROP_R0=1 and addr==0, the handshake still completes but the slot is not filled (it is cleared if it was granted).
- Grant (combinational from slot state):
  - only one slot full -> that slot wins.
  - both full -> mem wins, unless starve_cnt==STARVE_LIMIT, in which case alu wins.
- On the grant edge: the output registers load the winner's addr/data with wr_en=1 and the winner's slot clears, unless it is refilled on the same edge. With no grant, wr_en=0 and wr_addr/wr_data hold their values.
- Latency: acceptance at edge N -> wr_en high during cycle N+1..N+2 (after edge N+1) -> register file commits at edge N+2. Sustained throughput is one write per cycle across both sources. Each source can sustain one per cycle only when the other is idle.
- starve_cnt:
  - +1 (saturating at STARVE_LIMIT) on each edge where the alu slot is full and not granted.
  - reset to 0 when alu is granted or the alu slot is empty.
- Hazard: chkN_hit = any of the following for chkN_addr:
  - alu slot full with matching addr
  - mem slot full with matching addr
  - wr_en=1 with matching wr_addr
  - Forced to 0 when chkN_addr==0 and DROP_R0=1.
  - Purely combinational.
- Same address in both slots: commit order follows grant order; the last granted write wins in the register file. No merging.

Decomposition:
- Package reg_wb_pkg:
  - DATA_W/ADDR_W defaults
  - source-select encoding SRC_ALU=0, SRC_MEM=1
  - starve counter width function ceil(log2(STARVE_LIMIT+1))
- Sub-module wb_hold_slot: one-entry valid/ready holding register with a take/clear input, the DROP_R0 filter, and an addr-match output. It is instantiated once per source. Arbitration, the starve counter and the output registers live in the top.

Test Plan:
- Reset mid-stream: both slots full, assert rst one cycle -> next cycle wr_en=0, wr_addr=0, wr_data=0, both readies 1, no later write of the discarded data.
- Single ALU write addr=7 data=0xDEADBEEF accepted at edge N -> wr_en=1, wr_addr=7, wr_data=0xDEADBEEF after edge N+1, wr_en=0 after edge N+2.
- Both valid, alu addr=3, mem addr=4, same edge -> addr 4 written first, addr 3 on the next cycle. alu_ready=0 for the one cycle alu waits.
- Continuous mem stream every cycle plus one ALU request, STARVE_LIMIT=3 -> ALU is granted on the 4th cycle its slot is full. mem_ready drops to 0 for exactly one cycle.
- alu addr=0 data=0x1234 with DROP_R0=1 -> handshake completes, wr_en never asserts, chk0_addr=0 gives chk0_hit=0.
- mem addr=9 accepted, chk0_addr=9 -> chk0_hit=1 from the cycle after acceptance through the cycle wr_en is high, then 0. chk1_addr=10 -> chk1_hit=0 throughout.

Source files
------------

// File: rtl/reg_wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reg_wb_pkg
//  Description : Shared defaults, source-select encoding and the starve
//                counter width helper for the register writeback arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package reg_wb_pkg;

    localparam int c_DATA_W_DEFAULT = 32;
    localparam int c_ADDR_W_DEFAULT = 5;

    // Which writeback source owns the register file port this cycle
    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } wb_src_e;

    // Bits needed to count from 0 up to and including the starvation limit
    function automatic int starve_cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_hold_slot.sv
`default_nettype none
// ============================================================================
//  Module      : wb_hold_slot
//  Description : One-entry writeback holding register with a valid/ready
//                input, a take strobe from the arbiter, an optional discard
//                of register-0 writes and two address-match outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_hold_slot
    import reg_wb_pkg::*;
#(
    parameter int DATA_W  = c_DATA_W_DEFAULT,
    parameter int ADDR_W  = c_ADDR_W_DEFAULT,
    parameter int DROP_R0 = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_take,
    output logic              o_full,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_data,
    input  logic [ADDR_W-1:0] i_cmp0_addr,
    input  logic [ADDR_W-1:0] i_cmp1_addr,
    output logic              o_cmp0_hit,
    output logic              o_cmp1_hit
);

    logic              r_full;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              w_accept;
    logic              w_drop;

    // Ready only looks at stored state and the arbiter's take, never at valid
    assign o_ready  = !rst && (!r_full || i_take);
    assign w_accept = i_valid && o_ready;
    // Register 0 is hardwired; its writes complete the handshake but vanish
    assign w_drop   = (DROP_R0 != 0) && (i_addr == '0);

    // Slot storage: a new entry wins over the take so back-to-back flow works
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
        end else if (w_accept && !w_drop) begin
            r_full <= 1'b1;
            r_addr <= i_addr;
            r_data <= i_data;
        end else if (i_take) begin
            r_full <= 1'b0;
        end
    end

    assign o_full     = r_full;
    assign o_addr     = r_addr;
    assign o_data     = r_data;
    assign o_cmp0_hit = r_full && (r_addr == i_cmp0_addr);
    assign o_cmp1_hit = r_full && (r_addr == i_cmp1_addr);

endmodule
`default_nettype wire

// File: rtl/reg_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : reg_wb_arbiter
//  Description : Shares the register file write port between the ALU and
//                load-return writeback paths. Fixed priority to loads with
//                an anti-starvation override for the ALU, registered write
//                outputs and combinational pending-write hazard detection.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_wb_arbiter
    import reg_wb_pkg::*;
#(
    parameter int DATA_W       = c_DATA_W_DEFAULT,
    parameter int ADDR_W       = c_ADDR_W_DEFAULT,
    parameter int STARVE_LIMIT = 3,
    parameter int DROP_R0      = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] chk0_addr,
    input  logic [ADDR_W-1:0] chk1_addr,
    output logic              chk0_hit,
    output logic              chk1_hit
);

    localparam int              c_SW         = starve_cnt_width(STARVE_LIMIT);
    localparam logic [c_SW-1:0] c_STARVE_MAX = c_SW'(STARVE_LIMIT);

    logic              w_alu_full;
    logic [ADDR_W-1:0] w_alu_addr;
    logic [DATA_W-1:0] w_alu_data;
    logic              w_alu_hit0;
    logic              w_alu_hit1;
    logic              w_mem_full;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_data;
    logic              w_mem_hit0;
    logic              w_mem_hit1;

    logic              w_grant;
    wb_src_e           w_sel;
    logic              w_take_alu;
    logic              w_take_mem;
    logic              w_starved;

    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic [c_SW-1:0]   r_starve;

    wb_hold_slot #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .DROP_R0 (DROP_R0)
    ) u_alu_slot (
        .clk         (clk),
        .rst         (rst),
        .i_valid     (alu_valid),
        .o_ready     (alu_ready),
        .i_addr      (alu_addr),
        .i_data      (alu_data),
        .i_take      (w_take_alu),
        .o_full      (w_alu_full),
        .o_addr      (w_alu_addr),
        .o_data      (w_alu_data),
        .i_cmp0_addr (chk0_addr),
        .i_cmp1_addr (chk1_addr),
        .o_cmp0_hit  (w_alu_hit0),
        .o_cmp1_hit  (w_alu_hit1)
    );

    wb_hold_slot #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .DROP_R0 (DROP_R0)
    ) u_mem_slot (
        .clk         (clk),
        .rst         (rst),
        .i_valid     (mem_valid),
        .o_ready     (mem_ready),
        .i_addr      (mem_addr),
        .i_data      (mem_data),
        .i_take      (w_take_mem),
        .o_full      (w_mem_full),
        .o_addr      (w_mem_addr),
        .o_data      (w_mem_data),
        .i_cmp0_addr (chk0_addr),
        .i_cmp1_addr (chk1_addr),
        .o_cmp0_hit  (w_mem_hit0),
        .o_cmp1_hit  (w_mem_hit1)
    );

    // Loads normally win a tie; a starved ALU entry takes the port once
    assign w_starved  = (r_starve == c_STARVE_MAX);
    assign w_grant    = w_alu_full || w_mem_full;
    assign w_sel      = (w_mem_full && !(w_alu_full && w_starved)) ? SRC_MEM : SRC_ALU;
    assign w_take_alu = w_grant && (w_sel == SRC_ALU);
    assign w_take_mem = w_grant && (w_sel == SRC_MEM);

    // Register file write port; address/data hold when nothing is granted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= w_grant;
            if (w_grant) begin
                r_wr_addr <= (w_sel == SRC_MEM) ? w_mem_addr : w_alu_addr;
                r_wr_data <= (w_sel == SRC_MEM) ? w_mem_data : w_alu_data;
            end
        end
    end

    // Count consecutive cycles the ALU entry waits behind a load
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve <= '0;
        end else if (w_alu_full && !w_take_alu) begin
            if (!w_starved) begin
                r_starve <= r_starve + 1'b1;
            end
        end else begin
            r_starve <= '0;
        end
    end

    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;

    // A read of register 0 never needs a stall when its writes are discarded
    assign chk0_hit = !((DROP_R0 != 0) && (chk0_addr == '0)) &&
                      (w_alu_hit0 || w_mem_hit0 || (r_wr_en && (r_wr_addr == chk0_addr)));
    assign chk1_hit = !((DROP_R0 != 0) && (chk1_addr == '0)) &&
                      (w_alu_hit1 || w_mem_hit1 || (r_wr_en && (r_wr_addr == chk1_addr)));

endmodule
`default_nettype wire

// File: tb/tb_reg_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_wb_arbiter
//  Description : Scoreboard bench for reg_wb_arbiter. Stimulus pushes each
//                expected register-file write (addr, data, cycle) into a
//                queue; a negedge monitor pops and compares every wr_en pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_wb_arbiter;

    localparam int c_DW = 32;
    localparam int c_AW = 5;

    typedef struct {
        logic [c_AW-1:0] addr;
        logic [c_DW-1:0] data;
        int              cyc;
    } wr_exp_t;

    logic            clk;
    logic            rst;
    logic            alu_valid;
    logic            alu_ready;
    logic [c_AW-1:0] alu_addr;
    logic [c_DW-1:0] alu_data;
    logic            mem_valid;
    logic            mem_ready;
    logic [c_AW-1:0] mem_addr;
    logic [c_DW-1:0] mem_data;
    logic            wr_en;
    logic [c_AW-1:0] wr_addr;
    logic [c_DW-1:0] wr_data;
    logic [c_AW-1:0] chk0_addr;
    logic [c_AW-1:0] chk1_addr;
    logic            chk0_hit;
    logic            chk1_hit;

    int      checks   = 0;
    int      failures = 0;
    int      cyc      = 0;
    wr_exp_t sb[$];

    reg_wb_arbiter #(
        .DATA_W       (c_DW),
        .ADDR_W       (c_AW),
        .STARVE_LIMIT (3),
        .DROP_R0      (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_addr  (alu_addr),
        .alu_data  (alu_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .chk0_addr (chk0_addr),
        .chk1_addr (chk1_addr),
        .chk0_hit  (chk0_hit),
        .chk1_hit  (chk1_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter: after edge k (sampled later in the cycle) cyc == k
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [c_AW-1:0] a, input logic [c_DW-1:0] d, input int c);
        wr_exp_t e;
        e.addr = a;
        e.data = d;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    // Monitor: every write pulse must match the oldest expected write
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL wr_unexpected: got addr=%0h data=%0h cycle=%0d expected no write",
                         wr_addr, wr_data, cyc);
            end else begin
                wr_exp_t e;
                e = sb.pop_front();
                if (wr_addr !== e.addr || wr_data !== e.data || cyc != e.cyc) begin
                    failures++;
                    $display("FAIL wr_match: got addr=%0h data=%0h cycle=%0d expected addr=%0h data=%0h cycle=%0d",
                             wr_addr, wr_data, cyc, e.addr, e.data, e.cyc);
                end
            end
        end
    end

    logic [31:0] mstream [0:4];
    logic        exp_mrdy [0:5];
    logic        exp_ardy [0:5];

    initial begin
        int k;
        int idx;
        logic rdy;

        rst = 1'b1;
        alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
        mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
        chk0_addr = '0;   chk1_addr = '0;

        // Reset state
        step(); step();
        check("rst_alu_ready", alu_ready, 0);
        check("rst_mem_ready", mem_ready, 0);
        check("rst_wr_en", wr_en, 0);
        rst = 1'b0;
        #1;
        check("post_rst_alu_ready", alu_ready, 1);
        check("post_rst_mem_ready", mem_ready, 1);
        step();

        // Single ALU write
        k = cyc;
        alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'hDEADBEEF;
        push(5'd7, 32'hDEADBEEF, k + 2);
        step();
        alu_valid = 1'b0;
        step();
        check("single_wr_en_high", wr_en, 1);
        step();
        check("single_wr_en_low", wr_en, 0);
        step();

        // Simultaneous requests: load first, ALU waits one cycle
        k = cyc;
        alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'hA0A0_0003;
        mem_valid = 1'b1; mem_addr = 5'd4; mem_data = 32'hB0B0_0004;
        push(5'd4, 32'hB0B0_0004, k + 2);
        push(5'd3, 32'hA0A0_0003, k + 3);
        step();
        alu_valid = 1'b0; mem_valid = 1'b0;
        check("tie_alu_ready_wait", alu_ready, 0);
        check("tie_mem_ready", mem_ready, 1);
        step();
        check("tie_alu_ready_granted", alu_ready, 1);
        step(); step(); step();

        // Same address in both slots: load lands first, ALU value survives
        k = cyc;
        alu_valid = 1'b1; alu_addr = 5'd6; alu_data = 32'h0000_0001;
        mem_valid = 1'b1; mem_addr = 5'd6; mem_data = 32'h0000_0002;
        push(5'd6, 32'h0000_0002, k + 2);
        push(5'd6, 32'h0000_0001, k + 3);
        step();
        alu_valid = 1'b0; mem_valid = 1'b0;
        step(); step(); step();

        // Continuous load stream starves the ALU for three cycles
        mstream[0] = 32'h1000_0000; mstream[1] = 32'h1000_0001; mstream[2] = 32'h1000_0002;
        mstream[3] = 32'h1000_0003; mstream[4] = 32'h1000_0004;
        exp_mrdy[0] = 1; exp_mrdy[1] = 1; exp_mrdy[2] = 1; exp_mrdy[3] = 1; exp_mrdy[4] = 0; exp_mrdy[5] = 1;
        exp_ardy[0] = 1; exp_ardy[1] = 0; exp_ardy[2] = 0; exp_ardy[3] = 0; exp_ardy[4] = 1; exp_ardy[5] = 1;
        k = cyc;
        push(5'd12, mstream[0], k + 2);
        push(5'd13, mstream[1], k + 3);
        push(5'd14, mstream[2], k + 4);
        push(5'd5,  32'h0000_0055, k + 5);
        push(5'd15, mstream[3], k + 6);
        push(5'd16, mstream[4], k + 7);
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'h0000_0055;
        idx = 0;
        mem_valid = 1'b1; mem_addr = 5'd12; mem_data = mstream[0];
        for (int j = 0; j < 6; j++) begin
            check($sformatf("starve_mem_ready_%0d", j), mem_ready, exp_mrdy[j]);
            check($sformatf("starve_alu_ready_%0d", j), alu_ready, exp_ardy[j]);
            rdy = mem_ready;
            step();
            if (j == 0) alu_valid = 1'b0;
            if (rdy) idx++;
            if (idx >= 5) begin
                mem_valid = 1'b0;
            end else begin
                mem_addr = 5'(12 + idx);
                mem_data = mstream[idx];
            end
        end
        mem_valid = 1'b0;
        step(); step(); step();

        // Register-0 write is accepted and dropped
        chk0_addr = 5'd0;
        alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'h0000_1234;
        check("r0_alu_ready", alu_ready, 1);
        step();
        alu_valid = 1'b0;
        check("r0_chk0_hit", chk0_hit, 0);
        check("r0_slot_empty_ready", alu_ready, 1);
        step(); step();

        // Hazard window for a load to register 9
        chk0_addr = 5'd9; chk1_addr = 5'd10;
        #1;
        check("haz_before", chk0_hit, 0);
        k = cyc;
        mem_valid = 1'b1; mem_addr = 5'd9; mem_data = 32'h9999_0009;
        push(5'd9, 32'h9999_0009, k + 2);
        step();
        mem_valid = 1'b0;
        check("haz_slot_full", chk0_hit, 1);
        check("haz_chk1_a", chk1_hit, 0);
        step();
        check("haz_wr_en", chk0_hit, 1);
        check("haz_chk1_b", chk1_hit, 0);
        step();
        check("haz_after", chk0_hit, 0);
        check("haz_chk1_c", chk1_hit, 0);
        step();

        // Reset with both slots holding entries discards them
        alu_valid = 1'b1; alu_addr = 5'd20; alu_data = 32'hAAAA_0020;
        mem_valid = 1'b1; mem_addr = 5'd21; mem_data = 32'hBBBB_0021;
        step();
        alu_valid = 1'b0; mem_valid = 1'b0;
        rst = 1'b1;
        step();
        check("midrst_alu_ready_low", alu_ready, 0);
        check("midrst_mem_ready_low", mem_ready, 0);
        rst = 1'b0;
        #1;
        check("midrst_wr_en", wr_en, 0);
        check("midrst_wr_addr", wr_addr, 0);
        check("midrst_wr_data", wr_data, 0);
        check("midrst_alu_ready", alu_ready, 1);
        check("midrst_mem_ready", mem_ready, 1);
        for (int j = 0; j < 5; j++) step();

        check("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
